// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: one-hot T1..T6 ring counter plus opcode decode into the control word.
// Controls are combinational from ring state and opcode; HLT freezes the ring at T4 until clear.
module sap1_controller #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] opcode,
  output logic [5:0] t_state,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo,
  output logic       halt
);

  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;

  // Raw vector rather than an enum so that upset, non-one-hot codes stay representable.
  logic [5:0] ring;
  logic       halt_q;
  logic       hlt_t4;

  assign t_state = ring;
  assign hlt_t4  = (ring == T4) && (opcode == OP_HLT);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      ring   <= T1;
      halt_q <= 1'b0;
    end else if (halt_q) begin
      ring <= T4;
    end else begin
      case (ring)
        T1: ring <= T2;
        T2: ring <= T3;
        T3: ring <= T4;
        T4: begin
          if (opcode == OP_HLT) halt_q <= 1'b1;
          else                  ring   <= T5;
        end
        T5:      ring <= T6;
        T6:      ring <= T1;
        default: ring <= T1;
      endcase
    end
  end

  always_comb begin
    cp = 1'b0;
    ep = 1'b0;
    lm = 1'b0;
    ce = 1'b0;
    li = 1'b0;
    ei = 1'b0;
    la = 1'b0;
    ea = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lb = 1'b0;
    lo = 1'b0;
    halt = !clear && (halt_q || hlt_t4);
    // Illegal ring codes match no item, so no bus driver can ever be enabled by them.
    if (!clear && !halt_q) begin
      case (ring)
        T1: begin ep = 1'b1; lm = 1'b1; end
        T2: cp = 1'b1;
        T3: begin ce = 1'b1; li = 1'b1; end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin ei = 1'b1; lm = 1'b1; end
            OP_OUT:  begin ea = 1'b1; lo = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA:         begin ce = 1'b1; la = 1'b1; end
            OP_ADD, OP_SUB: begin ce = 1'b1; lb = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD:  begin eu = 1'b1; la = 1'b1; end
            OP_SUB:  begin su = 1'b1; eu = 1'b1; la = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
